// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_pkg
// Brief   : Opcode, bus-source code and branch-condition constants shared by
//           the single-bus datapath and its ALU.
// Rev     : 1.0  initial release
// ============================================================================
package cpu_pkg;

   // Opcodes, IR[31:27]
   localparam logic [4:0] C_OP_LD   = 5'b00000;
   localparam logic [4:0] C_OP_LDI  = 5'b00001;
   localparam logic [4:0] C_OP_ST   = 5'b00010;
   localparam logic [4:0] C_OP_ADD  = 5'b00011;
   localparam logic [4:0] C_OP_SUB  = 5'b00100;
   localparam logic [4:0] C_OP_AND  = 5'b00101;
   localparam logic [4:0] C_OP_OR   = 5'b00110;
   localparam logic [4:0] C_OP_ROR  = 5'b00111;
   localparam logic [4:0] C_OP_ROL  = 5'b01000;
   localparam logic [4:0] C_OP_SHR  = 5'b01001;
   localparam logic [4:0] C_OP_SHRA = 5'b01010;
   localparam logic [4:0] C_OP_SHL  = 5'b01011;
   localparam logic [4:0] C_OP_ADDI = 5'b01100;
   localparam logic [4:0] C_OP_ANDI = 5'b01101;
   localparam logic [4:0] C_OP_ORI  = 5'b01110;
   localparam logic [4:0] C_OP_DIV  = 5'b01111;
   localparam logic [4:0] C_OP_MUL  = 5'b10000;
   localparam logic [4:0] C_OP_NEG  = 5'b10001;
   localparam logic [4:0] C_OP_NOT  = 5'b10010;
   localparam logic [4:0] C_OP_BR   = 5'b10011;
   localparam logic [4:0] C_OP_OUT  = 5'b10110;

   // Bus-source codes; GPRs occupy 0..15
   localparam logic [4:0] C_SRC_HI      = 5'd16;
   localparam logic [4:0] C_SRC_LO      = 5'd17;
   localparam logic [4:0] C_SRC_ZHI     = 5'd18;
   localparam logic [4:0] C_SRC_ZLO     = 5'd19;
   localparam logic [4:0] C_SRC_PC      = 5'd20;
   localparam logic [4:0] C_SRC_MDR     = 5'd21;
   localparam logic [4:0] C_SRC_INPORT  = 5'd22;
   localparam logic [4:0] C_SRC_C       = 5'd23;
   localparam logic [4:0] C_SRC_Y       = 5'd24;
   localparam logic [4:0] C_SRC_OUTPORT = 5'd25;
   localparam logic [4:0] C_SRC_NONE    = 5'd31;

   // Branch conditions, IR[20:19]
   localparam logic [1:0] C_CON_EQZ = 2'b00;
   localparam logic [1:0] C_CON_NEZ = 2'b01;
   localparam logic [1:0] C_CON_POS = 2'b10;
   localparam logic [1:0] C_CON_NEG = 2'b11;

   function automatic logic [31:0] imm_sext(input logic [31:0] ir);
      return {{13{ir[18]}}, ir[18:0]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_alu.sv
`default_nettype none
// ============================================================================
// Module  : cpu_alu
// Brief   : Combinational ALU, A = Y and B = bus, 64-bit result for Z.
//           Multiply/divide present only when MULDIV_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
module cpu_alu
   import cpu_pkg::*;
#(
   parameter int DATA_W = 32
)(
   input  logic [DATA_W-1:0]   a,
   input  logic [DATA_W-1:0]   b,
   input  logic [4:0]          opcode,
   input  logic                inc_pc,
   output logic [2*DATA_W-1:0] result
);
   localparam int SH_W = $clog2(DATA_W);
   localparam int W2   = 2 * DATA_W;

   logic [SH_W-1:0]   w_shamt;
   logic [W2-1:0]     w_ror;
   logic [W2-1:0]     w_rol;
   logic [DATA_W-1:0] w_lo;
   logic              w_sext;
   logic              w_wide;
   logic [W2-1:0]     w_full;

   assign w_shamt = b[SH_W-1:0];
   // Rotates fall out of shifting the operand concatenated with itself
   assign w_ror   = {a, a} >> w_shamt;
   assign w_rol   = {a, a} << w_shamt;

   always_comb begin
      w_lo   = '0;
      w_sext = 1'b0;
      w_wide = 1'b0;
      w_full = '0;
      if (inc_pc) begin
         w_lo = b + DATA_W'(1);
      end else begin
         case (opcode)
            C_OP_LD, C_OP_LDI, C_OP_ST, C_OP_ADD, C_OP_ADDI, C_OP_BR: begin
               w_lo   = a + b;
               w_sext = 1'b1;
            end
            C_OP_SUB: begin
               w_lo   = a - b;
               w_sext = 1'b1;
            end
            C_OP_AND, C_OP_ANDI: w_lo = a & b;
            C_OP_OR,  C_OP_ORI:  w_lo = a | b;
            C_OP_ROR:  w_lo = w_ror[DATA_W-1:0];
            C_OP_ROL:  w_lo = w_rol[W2-1:DATA_W];
            C_OP_SHR:  w_lo = a >> w_shamt;
            C_OP_SHRA: w_lo = $signed(a) >>> w_shamt;
            C_OP_SHL:  w_lo = a << w_shamt;
            C_OP_NEG:  w_lo = -b;
            C_OP_NOT:  w_lo = ~b;
`ifdef MULDIV_EN
            C_OP_MUL: begin
               w_wide = 1'b1;
               w_full = W2'($signed(a)) * W2'($signed(b));
            end
            C_OP_DIV: begin
               w_wide = 1'b1;
               if (b != '0)
                  w_full = {DATA_W'($signed(a) % $signed(b)), DATA_W'($signed(a) / $signed(b))};
            end
`endif
            default: ;
         endcase
      end
      result = w_wide ? w_full
                      : {(w_sext ? {DATA_W{w_lo[DATA_W-1]}} : {DATA_W{1'b0}}), w_lo};
   end

endmodule
`default_nettype wire

// File: rtl/cpu_datapath.sv
`default_nettype none
// ============================================================================
// Module  : cpu_datapath
// Brief   : Single-bus 32-bit datapath driven by an external control-step
//           sequencer. Define MULDIV_EN to enable ALU multiply/divide.
// Rev     : 1.0  initial release
// ============================================================================
module cpu_datapath
   import cpu_pkg::*;
#(
   parameter int MEM_DEPTH = 512,
   parameter int DATA_W    = 32
)(
   input  logic                         Clock,
   input  logic                         clear,
   input  logic                         HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin,
   input  logic                         HIout, LOout, ZHIout, ZLOout, PCout, MDRout,
   input  logic                         INPORTout, OUTPORTout, Cout, Yout,
   input  logic                         Gra, Grb, Grc, Rin, Rout, BAout,
   input  logic                         Read, IncPC, write,
   input  logic [DATA_W-1:0]            inportInput,
   input  logic [15:0]                  regIn,
   output logic [DATA_W-1:0]            busMuxOut,
   output logic [4:0]                   encoderOut,
   output logic                         CON,
   output logic [DATA_W-1:0]            BusMuxInR0, BusMuxInR1, BusMuxInR2, BusMuxInR3,
   output logic [DATA_W-1:0]            BusMuxInR4, BusMuxInR5, BusMuxInR6, BusMuxInR7,
   output logic [DATA_W-1:0]            BusMuxInR8, BusMuxInR9, BusMuxInR10, BusMuxInR11,
   output logic [DATA_W-1:0]            BusMuxInR12, BusMuxInR13, BusMuxInR14, BusMuxInR15,
   output logic [DATA_W-1:0]            BusMuxInHI, BusMuxInLO, BusMuxInZhi, BusMuxInZlo,
   output logic [DATA_W-1:0]            BusMuxInPC, BusMuxInMDR, BusMuxInInport, BusMuxInOutport,
   output logic [DATA_W-1:0]            BusMuxInY, IRregister, Cregister,
   output logic [$clog2(MEM_DEPTH)-1:0] marToRam
);
   localparam int ADDR_W = $clog2(MEM_DEPTH);

   logic [DATA_W-1:0]   r_gpr [16];
   logic [DATA_W-1:0]   r_hi, r_lo, r_pc, r_ir, r_mdr, r_y, r_inport, r_outport;
   logic [ADDR_W-1:0]   r_mar;
   logic [2*DATA_W-1:0] r_z;
   logic                r_con;
   logic [DATA_W-1:0]   r_mem [MEM_DEPTH];

   logic [3:0]          w_field;
   logic [DATA_W-1:0]   w_c, w_bus, w_ram_rd;
   logic [4:0]          w_enc;
   logic [2*DATA_W-1:0] w_alu;
   logic                w_cond;

   always_comb begin
      w_field = '0;
      if (Gra)      w_field = r_ir[26:23];
      else if (Grb) w_field = r_ir[22:19];
      else if (Grc) w_field = r_ir[18:15];
   end

   assign w_c      = imm_sext(r_ir);
   assign w_ram_rd = r_mem[r_mar];

   // Priority encoder: lowest code wins, so a selected GPR beats every other source
   always_comb begin
      w_enc = C_SRC_NONE;
      w_bus = '0;
      if (Rout || BAout) begin
         w_enc = {1'b0, w_field};
         w_bus = (BAout && (w_field == 4'd0)) ? '0 : r_gpr[w_field];
      end
      else if (HIout)      begin w_enc = C_SRC_HI;      w_bus = r_hi;                  end
      else if (LOout)      begin w_enc = C_SRC_LO;      w_bus = r_lo;                  end
      else if (ZHIout)     begin w_enc = C_SRC_ZHI;     w_bus = r_z[2*DATA_W-1:DATA_W]; end
      else if (ZLOout)     begin w_enc = C_SRC_ZLO;     w_bus = r_z[DATA_W-1:0];       end
      else if (PCout)      begin w_enc = C_SRC_PC;      w_bus = r_pc;                  end
      else if (MDRout)     begin w_enc = C_SRC_MDR;     w_bus = r_mdr;                 end
      else if (INPORTout)  begin w_enc = C_SRC_INPORT;  w_bus = r_inport;              end
      else if (Cout)       begin w_enc = C_SRC_C;       w_bus = w_c;                   end
      else if (Yout)       begin w_enc = C_SRC_Y;       w_bus = r_y;                   end
      else if (OUTPORTout) begin w_enc = C_SRC_OUTPORT; w_bus = r_outport;             end
   end

   always_comb begin
      w_cond = 1'b0;
      case (r_ir[20:19])
         C_CON_EQZ: w_cond = (w_bus == '0);
         C_CON_NEZ: w_cond = (w_bus != '0);
         C_CON_POS: w_cond = ~w_bus[DATA_W-1];
         C_CON_NEG: w_cond = w_bus[DATA_W-1];
         default:   w_cond = 1'b0;
      endcase
   end

   cpu_alu #(.DATA_W(DATA_W)) u_alu (
      .a      (r_y),
      .b      (w_bus),
      .opcode (r_ir[31:27]),
      .inc_pc (IncPC),
      .result (w_alu)
   );

   always_ff @(posedge Clock) begin
      if (clear) begin
         for (int i = 0; i < 16; i++) r_gpr[i] <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_pc      <= '0;
         r_ir      <= '0;
         r_mar     <= '0;
         r_mdr     <= '0;
         r_y       <= '0;
         r_z       <= '0;
         r_inport  <= '0;
         r_outport <= '0;
         r_con     <= 1'b0;
      end else begin
         for (int i = 0; i < 16; i++)
            if (regIn[i] || (Rin && (w_field == 4'(i)))) r_gpr[i] <= w_bus;
         if (HIin)             r_hi  <= w_bus;
         if (LOin)             r_lo  <= w_bus;
         if (PCin && !IncPC)   r_pc  <= w_bus;
         if (IRin)             r_ir  <= w_bus;
         if (MARin)            r_mar <= w_bus[ADDR_W-1:0];
         if (MDRin)            r_mdr <= Read ? w_ram_rd : w_bus;
         if (Yin)              r_y   <= w_bus;
         if (Zin)              r_z   <= w_alu;
         if (CONin)            r_con <= w_cond;
         if (Rin && (r_ir[31:27] == C_OP_OUT)) r_outport <= w_bus;
         r_inport <= inportInput;
      end
   end

   // RAM is deliberately outside the clear domain
   always_ff @(posedge Clock) begin
      if (write) r_mem[r_mar] <= r_mdr;
   end

   assign busMuxOut       = w_bus;
   assign encoderOut      = w_enc;
   assign CON             = r_con;
   assign marToRam        = r_mar;
   assign BusMuxInR0      = r_gpr[0];
   assign BusMuxInR1      = r_gpr[1];
   assign BusMuxInR2      = r_gpr[2];
   assign BusMuxInR3      = r_gpr[3];
   assign BusMuxInR4      = r_gpr[4];
   assign BusMuxInR5      = r_gpr[5];
   assign BusMuxInR6      = r_gpr[6];
   assign BusMuxInR7      = r_gpr[7];
   assign BusMuxInR8      = r_gpr[8];
   assign BusMuxInR9      = r_gpr[9];
   assign BusMuxInR10     = r_gpr[10];
   assign BusMuxInR11     = r_gpr[11];
   assign BusMuxInR12     = r_gpr[12];
   assign BusMuxInR13     = r_gpr[13];
   assign BusMuxInR14     = r_gpr[14];
   assign BusMuxInR15     = r_gpr[15];
   assign BusMuxInHI      = r_hi;
   assign BusMuxInLO      = r_lo;
   assign BusMuxInZhi     = r_z[2*DATA_W-1:DATA_W];
   assign BusMuxInZlo     = r_z[DATA_W-1:0];
   assign BusMuxInPC      = r_pc;
   assign BusMuxInMDR     = r_mdr;
   assign BusMuxInInport  = r_inport;
   assign BusMuxInOutport = r_outport;
   assign BusMuxInY       = r_y;
   assign IRregister      = r_ir;
   assign Cregister       = w_c;

endmodule
`default_nettype wire

// File: tb/tb_cpu_datapath.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_datapath
// Brief   : Self-checking bench: vector tables, instruction sequences and
//           random ALU stimulus against a reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_cpu_datapath;
   logic Clock = 1'b0;
   logic clear;
   logic HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin;
   logic HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, OUTPORTout, Cout, Yout;
   logic Gra, Grb, Grc, Rin, Rout, BAout;
   logic Read, IncPC, write;
   logic [31:0] inportInput;
   logic [15:0] regIn;
   logic [31:0] busMuxOut;
   logic [4:0]  encoderOut;
   logic        CON;
   logic [15:0][31:0] gpr;
   logic [31:0] dHI, dLO, dZhi, dZlo, dPC, dMDR, dIn, dOut, dY, dIR, dC;
   logic [8:0]  marToRam;

   int checks = 0;
   int errors = 0;

   always #5 Clock = ~Clock;

   cpu_datapath dut (
      .Clock(Clock), .clear(clear),
      .HIin(HIin), .LOin(LOin), .PCin(PCin), .MDRin(MDRin), .Zin(Zin), .Yin(Yin),
      .MARin(MARin), .IRin(IRin), .CONin(CONin),
      .HIout(HIout), .LOout(LOout), .ZHIout(ZHIout), .ZLOout(ZLOout), .PCout(PCout),
      .MDRout(MDRout), .INPORTout(INPORTout), .OUTPORTout(OUTPORTout), .Cout(Cout), .Yout(Yout),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
      .Read(Read), .IncPC(IncPC), .write(write),
      .inportInput(inportInput), .regIn(regIn),
      .busMuxOut(busMuxOut), .encoderOut(encoderOut), .CON(CON),
      .BusMuxInR0(gpr[0]),   .BusMuxInR1(gpr[1]),   .BusMuxInR2(gpr[2]),   .BusMuxInR3(gpr[3]),
      .BusMuxInR4(gpr[4]),   .BusMuxInR5(gpr[5]),   .BusMuxInR6(gpr[6]),   .BusMuxInR7(gpr[7]),
      .BusMuxInR8(gpr[8]),   .BusMuxInR9(gpr[9]),   .BusMuxInR10(gpr[10]), .BusMuxInR11(gpr[11]),
      .BusMuxInR12(gpr[12]), .BusMuxInR13(gpr[13]), .BusMuxInR14(gpr[14]), .BusMuxInR15(gpr[15]),
      .BusMuxInHI(dHI), .BusMuxInLO(dLO), .BusMuxInZhi(dZhi), .BusMuxInZlo(dZlo),
      .BusMuxInPC(dPC), .BusMuxInMDR(dMDR), .BusMuxInInport(dIn), .BusMuxInOutport(dOut),
      .BusMuxInY(dY), .IRregister(dIR), .Cregister(dC), .marToRam(marToRam)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      {HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin} = '0;
      {HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, OUTPORTout, Cout, Yout} = '0;
      {Gra, Grb, Grc, Rin, Rout, BAout, Read, IncPC, write} = '0;
      regIn = '0;
   endtask

   // One control step: strobes set beforehand apply to exactly one edge
   task automatic tick();
      @(posedge Clock);
      #1;
      idle();
   endtask

   // Latch v into INPORT, then leave INPORTout asserted for the caller's step
   task automatic load_in(input logic [31:0] v);
      inportInput = v;
      tick();
      INPORTout = 1'b1;
   endtask

   task automatic load_ir(input logic [31:0] v);
      load_in(v);
      IRin = 1'b1;
      tick();
   endtask

   // Reference ALU straight from the opcode table, Z = {hi, lo}
   function automatic logic [63:0] zmodel(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input bit inc);
      logic [31:0] r;
      int n;
`ifdef MULDIV_EN
      longint sa, sb, q, rm;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
`endif
      n = int'(b[4:0]);
      if (inc) return {32'd0, b + 32'd1};
      case (op)
         5'd0, 5'd1, 5'd2, 5'd3, 5'd12, 5'd19: begin r = a + b; return {{32{r[31]}}, r}; end
         5'd4:        begin r = a - b; return {{32{r[31]}}, r}; end
         5'd5, 5'd13: return {32'd0, a & b};
         5'd6, 5'd14: return {32'd0, a | b};
         5'd7:  return {32'd0, (n == 0) ? a : ((a >> n) | (a << (32 - n)))};
         5'd8:  return {32'd0, (n == 0) ? a : ((a << n) | (a >> (32 - n)))};
         5'd9:  return {32'd0, a >> n};
         5'd10: return {32'd0, (a >> n) | (a[31] ? ~(32'hFFFF_FFFF >> n) : 32'd0)};
         5'd11: return {32'd0, a << n};
         5'd17: return {32'd0, 32'd0 - b};
         5'd18: return {32'd0, ~b};
`ifdef MULDIV_EN
         5'd16: return sa * sb;
         5'd15: begin
            if (sb == 0) return 64'd0;
            q  = sa / sb;
            rm = sa % sb;
            return {rm[31:0], q[31:0]};
         end
`endif
         default: return 64'd0;
      endcase
   endfunction

   task automatic run_alu(input logic [4:0] op, input logic [26:0] irlow, input logic [31:0] a,
                          input logic [31:0] b, input bit inc, output logic [63:0] z);
      load_in(a); Yin = 1'b1; tick();
      load_ir({op, irlow});
      load_in(b); Zin = 1'b1; IncPC = inc; tick();
      z = {dZhi, dZlo};
   endtask

   typedef struct { logic [4:0] op; logic [31:0] a; logic [31:0] b; bit inc; logic [63:0] z; } alu_vec_t;
   typedef struct { logic [1:0] cc; logic [31:0] bus; bit exp; } con_vec_t;

   alu_vec_t avec [14];
   con_vec_t cvec [8];
   logic [4:0] ops [21];

   initial begin
      logic [63:0] z;
      logic [4:0]  op;
      logic [31:0] a, b;
      bit          inc;

      avec[0]  = '{5'b00011, 32'h7,        32'h9,        1'b0, 64'h0000_0000_0000_0010};
      avec[1]  = '{5'b00011, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD};
      avec[2]  = '{5'b00100, 32'h3,        32'h5,        1'b0, 64'hFFFF_FFFF_FFFF_FFFE};
      avec[3]  = '{5'b01010, 32'h80000000, 32'h1,        1'b0, 64'h0000_0000_C000_0000};
      avec[4]  = '{5'b01101, 32'h16,       32'h19,       1'b0, 64'h0000_0000_0000_0010};
      avec[5]  = '{5'b00110, 32'hF0F00000, 32'h00000F0F, 1'b0, 64'h0000_0000_F0F0_0F0F};
      avec[6]  = '{5'b00111, 32'h00000001, 32'h4,        1'b0, 64'h0000_0000_1000_0000};
      avec[7]  = '{5'b01000, 32'h80000001, 32'h1,        1'b0, 64'h0000_0000_0000_0003};
      avec[8]  = '{5'b01001, 32'h80000000, 32'd31,       1'b0, 64'h0000_0000_0000_0001};
      avec[9]  = '{5'b01011, 32'h3,        32'h22,       1'b0, 64'h0000_0000_0000_000C};
      avec[10] = '{5'b10001, 32'h1234,     32'h5,        1'b0, 64'h0000_0000_FFFF_FFFB};
      avec[11] = '{5'b10010, 32'h1234,     32'h0F0F0F0F, 1'b0, 64'h0000_0000_F0F0_F0F0};
      avec[12] = '{5'b00100, 32'h1234,     32'h7,        1'b1, 64'h0000_0000_0000_0008};
      avec[13] = '{5'b10100, 32'h1234,     32'h5678,     1'b0, 64'h0000_0000_0000_0000};

      cvec[0] = '{2'b11, 32'h80000001, 1'b1};
      cvec[1] = '{2'b00, 32'h00000005, 1'b0};
      cvec[2] = '{2'b00, 32'h00000000, 1'b1};
      cvec[3] = '{2'b01, 32'h00000000, 1'b0};
      cvec[4] = '{2'b01, 32'h00000007, 1'b1};
      cvec[5] = '{2'b10, 32'h80000000, 1'b0};
      cvec[6] = '{2'b10, 32'h00000001, 1'b1};
      cvec[7] = '{2'b11, 32'h7FFFFFFF, 1'b0};

      for (int i = 0; i < 21; i++) ops[i] = 5'(i);

      // ---------------- reset ----------------
      idle();
      inportInput = '0;
      clear = 1'b1;
      tick(); tick();
      clear = 1'b0;

      load_in(32'h1234); regIn = 16'h0020; tick();
      chk("r5_load", gpr[5], 32'h1234);
      load_in(32'hA5);
      {HIin, LOin, Yin, PCin, MARin, MDRin, IRin, Zin} = '1;
      regIn = 16'hFFDF;
      tick();
      chk("pre_hi", dHI, 32'hA5);
      load_in(32'h0); CONin = 1'b1; tick();
      chk("pre_con", CON, 1'b1);
      inportInput = 32'h1234;
      clear = 1'b1;
      Zin = 1'b1; HIin = 1'b1; regIn = 16'hFFFF;
      tick();
      clear = 1'b0;
      for (int i = 0; i < 16; i++) chk($sformatf("rst_r%0d", i), gpr[i], 32'h0);
      chk("rst_hi", dHI, 0);   chk("rst_lo", dLO, 0);   chk("rst_zhi", dZhi, 0);
      chk("rst_zlo", dZlo, 0); chk("rst_pc", dPC, 0);   chk("rst_mdr", dMDR, 0);
      chk("rst_in", dIn, 0);   chk("rst_out", dOut, 0); chk("rst_y", dY, 0);
      chk("rst_ir", dIR, 0);   chk("rst_c", dC, 0);     chk("rst_mar", marToRam, 0);
      chk("rst_con", CON, 0);
      chk("idle_enc", encoderOut, 5'd31);
      chk("idle_bus", busMuxOut, 32'h0);

      // ---------------- andi R2, R3, 0x19 ----------------
      load_in(32'h7);        MARin = 1'b1; tick();
      load_in(32'h69180019); MDRin = 1'b1; tick();
      write = 1'b1; tick();
      load_in(32'h7);  PCin = 1'b1; tick();
      load_in(32'h16); regIn = 16'h0008; tick();
      PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; tick();
      chk("t0_mar", marToRam, 9'd7);
      chk("t0_zlo", dZlo, 32'h8);
      ZLOout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; tick();
      chk("t1_pc", dPC, 32'h8);
      chk("t1_mdr", dMDR, 32'h69180019);
      MDRout = 1'b1; IRin = 1'b1; tick();
      chk("t2_ir", dIR, 32'h69180019);
      chk("t2_c", dC, 32'h19);
      Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; #1;
      chk("t3_enc", encoderOut, 5'd3);
      chk("t3_bus", busMuxOut, 32'h16);
      tick();
      Cout = 1'b1; Zin = 1'b1; #1;
      chk("t4_enc", encoderOut, 5'd23);
      tick();
      chk("t4_zlo", dZlo, 32'h10);
      chk("t4_zhi", dZhi, 32'h0);
      ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; tick();
      chk("t5_r2", gpr[2], 32'h10);
      chk("t5_mar", marToRam, 9'd7);

      // ---------------- memory ----------------
      load_in(32'h0A);       MARin = 1'b1; tick();
      load_in(32'hDEADBEEF); MDRin = 1'b1; tick();
      write = 1'b1; tick();
      load_in(32'h0); MDRin = 1'b1; tick();
      chk("mem_mdr_clr", dMDR, 32'h0);
      Read = 1'b1; MDRin = 1'b1; tick();
      chk("mem_rd", dMDR, 32'hDEADBEEF);
      chk("mem_mar", marToRam, 9'h0A);
      load_in(32'h7); MARin = 1'b1; tick();
      Read = 1'b1; MDRin = 1'b1; tick();
      chk("mem_rd7", dMDR, 32'h69180019);

      // ---------------- bus priority ----------------
      load_in(32'hAAAA); HIin = 1'b1; tick();
      load_in(32'hBBBB); LOin = 1'b1; tick();
      HIout = 1'b1; LOout = 1'b1; #1;
      chk("pri_hi_enc", encoderOut, 5'd16);
      chk("pri_hi_bus", busMuxOut, 32'hAAAA);
      idle();
      Grb = 1'b1; Rout = 1'b1; PCout = 1'b1; #1;
      chk("pri_gpr_enc", encoderOut, 5'd3);
      chk("pri_gpr_bus", busMuxOut, 32'h16);
      idle();
      PCout = 1'b1; Yout = 1'b1; #1;
      chk("pri_pc_enc", encoderOut, 5'd20);
      idle();

      // ---------------- out port ----------------
      load_ir(32'hB2000000);
      load_in(32'hCAFE); Gra = 1'b1; Rin = 1'b1; tick();
      chk("out_port", dOut, 32'hCAFE);
      chk("out_r4", gpr[4], 32'hCAFE);
      OUTPORTout = 1'b1; #1;
      chk("out_enc", encoderOut, 5'd25);
      chk("out_bus", busMuxOut, 32'hCAFE);
      idle();
      load_ir(32'h02000000);
      load_in(32'h1111); Gra = 1'b1; Rin = 1'b1; tick();
      chk("out_hold", dOut, 32'hCAFE);
      chk("out_r4b", gpr[4], 32'h1111);
      load_in(32'h2222); Gra = 1'b1; Rin = 1'b1; regIn = 16'h0010; tick();
      chk("dual_wr", gpr[4], 32'h2222);

      // ---------------- BAout ----------------
      load_in(32'h55); regIn = 16'h0001; tick();
      load_ir(32'h0);
      Gra = 1'b1; BAout = 1'b1; #1;
      chk("ba_r0_bus", busMuxOut, 32'h0);
      chk("ba_r0_enc", encoderOut, 5'd0);
      idle();
      Gra = 1'b1; Rout = 1'b1; #1;
      chk("rout_r0", busMuxOut, 32'h55);
      idle();
      load_ir(32'h02000000);
      Gra = 1'b1; BAout = 1'b1; #1;
      chk("ba_r4", busMuxOut, 32'h2222);
      idle();

      // ---------------- CON ----------------
      foreach (cvec[i]) begin
         load_ir({11'd0, cvec[i].cc, 19'd0});
         load_in(cvec[i].bus); CONin = 1'b1; tick();
         chk($sformatf("con_%0d", i), CON, cvec[i].exp);
      end

      // ---------------- ALU vectors ----------------
      foreach (avec[i]) begin
         run_alu(avec[i].op, 27'd0, avec[i].a, avec[i].b, avec[i].inc, z);
         chk($sformatf("alu_vec_%0d", i), z, avec[i].z);
      end

      // ---------------- random ALU ----------------
      for (int k = 0; k < 40; k++) begin
         op  = ops[$urandom_range(0, 20)];
         a   = $urandom;
         b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         inc = ($urandom_range(0, 7) == 0);
         run_alu(op, 27'($urandom), a, b, inc, z);
         chk($sformatf("alu_rand_%0d_op%0d", k, op), z, zmodel(op, a, b, inc));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- Single-bus 32-bit processor datapath: 16 GPRs, HI/LO, PC, IR, MAR, MDR, Y, 64-bit Z, in/out ports, a 512x32 RAM and a branch-condition (CON) flip-flop around one shared 32-bit bus.
- An external control-step sequencer drives every register enable and bus-source strobe directly.
- The block computes, stores and exposes register contents for debug; it has no sequencer of its own.

Parameters:
- MEM_DEPTH, 512, RAM words; the address is MAR[8:0].
- DATA_W, 32, bus and register width.

Ports:
- Clock  input  1  single clock; all state updates on its rising edge.
- clear  input  1  synchronous active-high reset.
- HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin  input  1 each  register load enables.
- HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, OUTPORTout, Cout, Yout  input  1 each  bus-source strobes.
- Gra, Grb, Grc, Rin, Rout, BAout  input  1 each  IR-field GPR select and read/write strobes.
- Read, IncPC, write  input  1 each  memory read, PC increment, memory write.
- inportInput  input  32  external input-port data.
- regIn  input  16  one-hot direct GPR load enables (R0..R15), ORed with the select-decoded Rin.
- busMuxOut  output  32  current bus value.
- encoderOut  output  5  code of the active bus source.
- CON  output  1  condition flip-flop.
- BusMuxInR0..R15, BusMuxInHI, BusMuxInLO, BusMuxInZhi, BusMuxInZlo, BusMuxInPC, BusMuxInMDR, BusMuxInInport, BusMuxInOutport, BusMuxInY, IRregister, Cregister  output  32 each  debug copies of register contents.
- marToRam  output  9  MAR[8:0].

Behaviour:
- Reset: on a rising Clock edge with clear=1, all registers (GPRs, HI, LO, PC, IR, MAR, MDR, Y, Z, INPORT, OUTPORT, CON) become 0. clear has priority over every enable. RAM contents are not cleared.
- Bus: a priority encoder maps the asserted strobe to a code and muxes that source onto the bus.
  - Codes: R0..R15 = 0..15, HI 16, LO 17, ZHI 18, ZLO 19, PC 20, MDR 21, INPORT 22, C 23, Y 24, OUTPORT 25.
  - GPR codes come from select logic; the lowest code wins on conflicts.
  - With no strobe asserted: code 31, bus = 0.
- Select/encode logic:
  - Field = IR[26:23] if Gra, else IR[22:19] if Grb, else IR[18:15] if Grc.
  - Rin enables a write to that GPR; Rout or BAout drives that GPR onto the bus.
  - Under BAout, R0 reads as 0.
- C = sign-extend(IR[18:0]); Cregister shows this value.
- Registers load from the bus on the edge when their enable is high.
  - INPORT loads inportInput every cycle.
  - OUTPORT loads from the bus when Rin=1 and IR[31:27]=10110.
- MDR:
  - When MDRin=1, MDR loads RAM[MAR[8:0]] if Read=1, otherwise the bus.
  - RAM read is combinational.
  - write=1 stores MDR into RAM[MAR[8:0]] at the edge.
- ALU (combinational), A = Y, B = bus, 64-bit result loaded into Z on Zin.
  - IncPC=1 overrides the opcode: result = B+1. Separately, PCin with IncPC=0 loads PC from the bus.
  - Opcodes (IR[31:27]):
    - 00000-00010, 01100, 10011: A+B
    - 00011: A+B
    - 00100: A-B
    - 00101, 01101: A&B
    - 00110, 01110: A|B
    - 00111: ror
    - 01000: rol
    - 01001: shr
    - 01010: shra
    - 01011: shl (shift amount B[4:0])
    - 10001: -B
    - 10010: ~B
  - Z high word = sign extension for add/sub; 0 for other single-word ops.
- CON: on CONin, CON <= condition on the bus per IR[20:19]: 00 bus==0, 01 bus!=0, 10 bus[31]==0, 11 bus[31]==1.
- Simultaneous regIn and decoded Rin to the same GPR: single write of the bus value.

Optional Feature:
- MULDIV_EN:
  - Defined: opcode 10000 gives Z = signed A*B (64-bit); opcode 01111 gives Z = {remainder A%B, quotient A/B} signed, and B=0 yields Z = 0.
  - Undefined: both opcodes give Z = 0.

Decomposition:
- Shared package cpu_pkg holds the opcode constants, bus-source encoder codes and the CON condition codes.
- One natural sub-module: cpu_alu (combinational, A/B/opcode/IncPC in, 64-bit result out).

Test Plan:
- Reset: load R5 = 0x1234 via inportInput, INPORTout and regIn=0x0020, then pulse clear → all BusMuxIn* = 0, CON=0, encoderOut=31 when idle.
- andi: RAM[7]=0x69180019, PC=7, R3=0x16.
  - Run T0..T5: PCout/MARin/IncPC/Zin; Read/MDRin/PCin; MDRout/IRin; Grb/Rout/Yin; Cout/Zin; ZLOout/Gra/Rin.
  - Expect IRregister=0x69180019, Cregister=0x19, Zlo=0x10, R2=0x10, marToRam=7.
- Memory: MAR=0x0A, MDR=0xDEADBEEF, write=1; then Read+MDRin → MDR=0xDEADBEEF.
- Shift/sub: Y=0x80000000, bus=1, shra → Zlo=0xC0000000. sub with Y=3, bus=5 → Zlo=0xFFFFFFFE, Zhi=0xFFFFFFFF.
- CON: IR[20:19]=11, bus=0x80000001, CONin → CON=1. IR[20:19]=00, bus=0 → CON=1.
- BAout: R0=0x55, Gra selects R0, BAout=1 → bus=0. With Rout=1 instead → bus=0x55.
